risc_hazard_fwd_unit: RTL and testbench

- Parametrised forwarding and hazard controller for the pipelined RISC core.
- Generalises the fixed 2-bit fwa/fwb forwarding to N configurable forwarding stages and a configurable load latency.
- Adds load-use stall generation, external hold, flush, and a saturating stall counter.
- Tracks in-flight destination registers internally in a shift pipeline fed from the decode stage. Drives the ALU operand muxes of the EX stage and the IF/ID hold.

---
 rtl/risc_hazard_fwd_unit.sv | 119 +++++++++++
 tb/tb_risc_hazard_fwd_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/risc_hazard_fwd_unit.sv
// Purpose: EX-stage operand forwarding select and load-use stall control over NUM_FWD in-flight slots.
// Latency: forwarding selects and stall are combinational; slot state advances one stage per clock.
// Backpressure: hold freezes all state; stall holds IF/ID and injects a bubble; flush squashes decode.
module risc_hazard_fwd_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(NUM_FWD + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic              id_is_load,
    input  logic              hold,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwa,
    output logic [SEL_W-1:0]  fwb,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Slot 0 is the EX instruction; slot k is k stages past EX.
    logic [NUM_FWD:0]  s_vld;
    logic [NUM_FWD:0]  s_wr;
    logic [NUM_FWD:0]  s_ld;
    logic [REG_AW-1:0] s_reg [0:NUM_FWD];

    // Source operand info only needed for the EX instruction.
    logic [REG_AW-1:0] ex_rs_q;
    logic [REG_AW-1:0] ex_rt_q;
    logic              ex_use_rs;
    logic              ex_use_rt;

    logic              stall_c;
    logic              load_slot0;
    logic [SEL_W-1:0]  fwa_c;
    logic [SEL_W-1:0]  fwb_c;

    // Load-use detect: a load still in slots 0..LOAD_LAT-1 cannot reach the consumer in time.
    always_comb begin
        stall_c = 1'b0;
        if (id_valid) begin
            for (int j = 0; j < LOAD_LAT; j++) begin
                if (s_vld[j] && s_wr[j] && s_ld[j]) begin
                    if (id_use_rs && (id_rs != '0) && (s_reg[j] == id_rs)) stall_c = 1'b1;
                    if (id_use_rt && (id_rt != '0) && (s_reg[j] == id_rt)) stall_c = 1'b1;
                end
            end
        end
    end

    // Forwarding select: scan oldest to youngest so the nearest producer overwrites older ones.
    always_comb begin
        fwa_c = '0;
        fwb_c = '0;
        for (int k = NUM_FWD; k >= 1; k--) begin
            if (s_vld[0] && s_vld[k] && s_wr[k] && !(s_ld[k] && (k <= LOAD_LAT))) begin
                if (ex_use_rs && (ex_rs_q != '0) && (s_reg[k] == ex_rs_q)) fwa_c = SEL_W'(k);
                if (ex_use_rt && (ex_rt_q != '0) && (s_reg[k] == ex_rt_q)) fwb_c = SEL_W'(k);
            end
        end
    end

    assign load_slot0 = id_valid && !stall_c && !flush;

    // Slot pipeline: shift every unheld cycle; slot 0 takes the decode instruction or a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_vld     <= '0;
            s_wr      <= '0;
            s_ld      <= '0;
            for (int i = 0; i <= NUM_FWD; i++) s_reg[i] <= '0;
            ex_rs_q   <= '0;
            ex_rt_q   <= '0;
            ex_use_rs <= 1'b0;
            ex_use_rt <= 1'b0;
        end else if (!hold) begin
            for (int i = 1; i <= NUM_FWD; i++) begin
                s_vld[i] <= s_vld[i-1];
                s_wr[i]  <= s_wr[i-1];
                s_ld[i]  <= s_ld[i-1];
                s_reg[i] <= s_reg[i-1];
            end
            s_vld[0]  <= load_slot0;
            s_wr[0]   <= load_slot0 && id_wr_en;
            s_ld[0]   <= load_slot0 && id_is_load;
            s_reg[0]  <= load_slot0 ? id_wr_reg : '0;
            ex_rs_q   <= load_slot0 ? id_rs : '0;
            ex_rt_q   <= load_slot0 ? id_rt : '0;
            ex_use_rs <= load_slot0 && id_use_rs;
            ex_use_rt <= load_slot0 && id_use_rt;
        end
    end

    // Stall cycle counter: counts unheld stall cycles and sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (!hold && stall_c && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall = stall_c;
    assign fwa   = fwa_c;
    assign fwb   = fwb_c;
    assign ex_rs = ex_rs_q;
    assign ex_rt = ex_rt_q;

endmodule

// File: tb/tb_risc_hazard_fwd_unit.sv
// Purpose: directed bench for risc_hazard_fwd_unit; default config and a NUM_FWD=3/LOAD_LAT=2/CNT_W=2 config.
// Latency: expectations are queued after inputs settle and popped on the following falling edge.
// Backpressure: hold and flush are driven directly from the stimulus table.
module tb_risc_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_use_rs = 1'b0;
    logic       id_use_rt = 1'b0;
    logic       id_wr_en = 1'b0;
    logic [4:0] id_wr_reg = '0;
    logic       id_is_load = 1'b0;
    logic       hold = 1'b0;
    logic       flush = 1'b0;

    logic        stall_a, stall_b;
    logic [1:0]  fwa_a, fwb_a, fwa_b, fwb_b;
    logic [4:0]  ex_rs_a, ex_rt_a, ex_rs_b, ex_rt_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    risc_hazard_fwd_unit u_dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .id_is_load(id_is_load), .hold(hold), .flush(flush), .stall(stall_a), .fwa(fwa_a),
        .fwb(fwb_a), .ex_rs(ex_rs_a), .ex_rt(ex_rt_a), .stall_cnt(cnt_a)
    );

    risc_hazard_fwd_unit #(.NUM_FWD(3), .LOAD_LAT(2), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .id_is_load(id_is_load), .hold(hold), .flush(flush), .stall(stall_b), .fwa(fwa_b),
        .fwb(fwb_b), .ex_rs(ex_rs_b), .ex_rt(ex_rt_b), .stall_cnt(cnt_b)
    );

    typedef struct {
        logic [63:0] name;
        bit          is_b;
        bit          st;
        int          fa;
        int          fb;
        int          cnt;
        bit          chk_ex;
        int          rs;
        int          rt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input logic [63:0] nm, input string field, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, field, act, req);
        end
    endtask

    // Monitor: pop one expectation per falling edge and compare against the selected DUT.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (!e.is_b) begin
                chk(e.name, "stall", int'(stall_a), int'(e.st));
                chk(e.name, "fwa", int'(fwa_a), e.fa);
                chk(e.name, "fwb", int'(fwb_a), e.fb);
                chk(e.name, "cnt", int'(cnt_a), e.cnt);
                if (e.chk_ex) begin
                    chk(e.name, "ex_rs", int'(ex_rs_a), e.rs);
                    chk(e.name, "ex_rt", int'(ex_rt_a), e.rt);
                end
            end else begin
                chk(e.name, "stall", int'(stall_b), int'(e.st));
                chk(e.name, "fwa", int'(fwa_b), e.fa);
                chk(e.name, "fwb", int'(fwb_b), e.fb);
                chk(e.name, "cnt", int'(cnt_b), e.cnt);
                if (e.chk_ex) begin
                    chk(e.name, "ex_rs", int'(ex_rs_b), e.rs);
                    chk(e.name, "ex_rt", int'(ex_rt_b), e.rt);
                end
            end
        end
    end

    // One decode cycle: inputs change just after the rising edge.
    task automatic cyc(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit wr, input int wreg, input bit ld, input bit h, input bit fl);
        @(posedge clk);
        #1;
        id_valid   = v;
        id_rs      = rs[4:0];
        id_rt      = rt[4:0];
        id_use_rs  = urs;
        id_use_rt  = urt;
        id_wr_en   = wr;
        id_wr_reg  = wreg[4:0];
        id_is_load = ld;
        hold       = h;
        flush      = fl;
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_out(input logic [63:0] nm, input bit b, input bit st, input int fa,
                              input int fb, input int cnt, input bit ce, input int rs, input int rt);
        exp_t x;
        x.name = nm; x.is_b = b; x.st = st; x.fa = fa; x.fb = fb; x.cnt = cnt;
        x.chk_ex = ce; x.rs = rs; x.rt = rt;
        sb.push_back(x);
    endtask

    initial begin
        // Power-on reset state of both configurations
        @(posedge clk); #1;
        expect_out("rst_a", 0, 0, 0, 0, 0, 1, 0, 0);
        expect_out("rst_b", 1, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk); #1;
        reset = 1'b1;

        // add r3 ; add r4,r3,r3 back-to-back
        cyc(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
        cyc(1, 3, 3, 1, 1, 1, 4, 0, 0, 0);
        nop(); expect_out("fwd1", 0, 0, 1, 1, 0, 1, 3, 3);
        // same with one intervening nop
        cyc(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
        nop();
        cyc(1, 3, 3, 1, 1, 1, 4, 0, 0, 0);
        nop(); expect_out("fwd2", 0, 0, 2, 2, 0, 1, 3, 3);
        // r5 produced twice, nearest wins; rt = r0 never forwards
        cyc(1, 1, 2, 1, 1, 1, 5, 0, 0, 0);
        cyc(1, 1, 2, 1, 1, 1, 5, 0, 0, 0);
        cyc(1, 5, 0, 1, 1, 1, 8, 0, 0, 0);
        nop(); expect_out("nearest", 0, 0, 1, 0, 0, 1, 5, 0);

        // Reset while slots are full clears everything immediately
        cyc(1, 5, 5, 1, 1, 1, 9, 0, 0, 0);
        reset = 1'b0;
        expect_out("midrst", 0, 0, 0, 0, 0, 1, 0, 0);

        // lw r6 ; add r7,r6,r0 : one stall cycle then forward from slot 2
        cyc(1, 1, 0, 1, 0, 1, 6, 1, 0, 0);
        reset = 1'b1;
        cyc(1, 6, 0, 1, 1, 1, 7, 0, 0, 0); expect_out("ldstall", 0, 1, 0, 0, 0, 1, 1, 0);
        cyc(1, 6, 0, 1, 1, 1, 7, 0, 0, 0); expect_out("ldbub", 0, 0, 0, 0, 1, 0, 0, 0);
        nop(); expect_out("ldfwd", 0, 0, 2, 0, 1, 1, 6, 0);

        // Load-use under a 3-cycle hold
        cyc(1, 1, 0, 1, 0, 1, 6, 1, 0, 0);
        cyc(1, 6, 0, 1, 1, 1, 7, 0, 1, 0); expect_out("hold0", 0, 1, 0, 0, 1, 1, 1, 0);
        cyc(1, 6, 0, 1, 1, 1, 7, 0, 1, 0); expect_out("hold1", 0, 1, 0, 0, 1, 1, 1, 0);
        cyc(1, 6, 0, 1, 1, 1, 7, 0, 1, 0); expect_out("hold2", 0, 1, 0, 0, 1, 1, 1, 0);
        cyc(1, 6, 0, 1, 1, 1, 7, 0, 0, 0); expect_out("hold_rel", 0, 1, 0, 0, 1, 1, 1, 0);
        cyc(1, 6, 0, 1, 1, 1, 7, 0, 0, 0); expect_out("hold_inc", 0, 0, 0, 0, 2, 0, 0, 0);
        nop(); expect_out("hold_fwd", 0, 0, 2, 0, 2, 1, 6, 0);

        // r0 never forwards and never stalls
        cyc(1, 1, 2, 1, 1, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 1, 1, 9, 0, 0, 0);
        nop(); expect_out("r0fwd", 0, 0, 0, 0, 2, 1, 0, 0);
        cyc(1, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 1, 1, 9, 0, 0, 0); expect_out("r0stall", 0, 0, 0, 0, 2, 1, 1, 0);

        // Flushed producer becomes a bubble
        cyc(1, 1, 2, 1, 1, 1, 10, 0, 0, 1);
        cyc(1, 10, 10, 1, 1, 1, 11, 0, 0, 0); expect_out("flush0", 0, 0, 0, 0, 2, 0, 0, 0);
        nop(); expect_out("flush1", 0, 0, 0, 0, 2, 1, 10, 10);
        // Flush together with a load-use stall still counts the stall
        cyc(1, 1, 0, 1, 0, 1, 12, 1, 0, 0);
        cyc(1, 12, 0, 1, 1, 1, 13, 0, 0, 1); expect_out("flstall", 0, 1, 0, 0, 2, 1, 1, 0);
        nop(); expect_out("flcnt", 0, 0, 0, 0, 3, 0, 0, 0);

        // Second configuration: LOAD_LAT=2, NUM_FWD=3, 2-bit counter
        nop();
        reset = 1'b0;
        expect_out("rst_b2", 1, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 1, 0, 1, 6, 1, 0, 0);
        reset = 1'b1;
        cyc(1, 6, 0, 1, 1, 1, 7, 0, 0, 0); expect_out("b_st1", 1, 1, 0, 0, 0, 1, 1, 0);
        cyc(1, 6, 0, 1, 1, 1, 7, 0, 0, 0); expect_out("b_st2", 1, 1, 0, 0, 1, 0, 0, 0);
        cyc(1, 6, 0, 1, 1, 1, 7, 0, 0, 0); expect_out("b_st3", 1, 0, 0, 0, 2, 0, 0, 0);
        nop(); expect_out("b_fwd", 1, 0, 3, 0, 2, 1, 6, 0);
        // Counter saturates at 3
        cyc(1, 1, 0, 1, 0, 1, 6, 1, 0, 0);
        cyc(1, 6, 0, 1, 1, 1, 7, 0, 0, 0); expect_out("b_sat1", 1, 1, 0, 0, 2, 1, 1, 0);
        cyc(1, 6, 0, 1, 1, 1, 7, 0, 0, 0); expect_out("b_sat2", 1, 1, 0, 0, 3, 0, 0, 0);
        cyc(1, 6, 0, 1, 1, 1, 7, 0, 0, 0); expect_out("b_sat3", 1, 0, 0, 0, 3, 0, 0, 0);
        nop();

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
